i2s_frame_controller: RTL

Bit-clock-domain sequencer for the I2S microphone front end. It generates the word-select (`i2s_ws`) that frames the serial stream into the I2S deserializer. It enforces a microphone warm-up period after enable, during which frames are clocked but discarded. It also gates which stereo slots downstream logic captures, and it shuts the link down cleanly on frame boundaries.

---
 rtl/i2s_frame_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_frame_controller.sv
// ---------------------------------------------------------------------------
// i2s_frame_controller
//
// Bit-clock sequencer for the I2S microphone front end. It generates the
// word select that frames the serial stream, discards a configurable number
// of warm-up frames after enable, gates which stereo slots downstream keeps,
// and shuts the link down only on frame boundaries.
//
// Parameters
//   SLOT_WIDTH     bclk cycles per channel slot (frame = 2*SLOT_WIDTH), 2..32
//   WARMUP_FRAMES  frames discarded after enable (0 = capture immediately)
//
// Ports
//   i2s_bclk     bit clock, all logic on posedge
//   sys_rst_n    asynchronous active-low reset
//   enable       level request to stream
//   left_en      capture left slot  (latched at frame boundaries)
//   right_en     capture right slot (latched at frame boundaries)
//   i2s_ws       word select, 0 = left, 1 = right
//   capture_en   high for every bclk of a slot that must be kept
//   frame_start  one-cycle pulse on the first bclk of each captured frame
//   running      high while in RUN
//   state        00 IDLE, 01 WARMUP, 10 RUN, 11 DRAIN
//   frame_count  frames completed with capture active (wraps)
// ---------------------------------------------------------------------------
module i2s_frame_controller #(
    parameter int SLOT_WIDTH    = 16,
    parameter int WARMUP_FRAMES = 1024
) (
    input  logic        i2s_bclk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic        left_en,
    input  logic        right_en,
    output logic        i2s_ws,
    output logic        capture_en,
    output logic        frame_start,
    output logic        running,
    output logic [1:0]  state,
    output logic [15:0] frame_count
);

    localparam int BW = (SLOT_WIDTH <= 2) ? 1 : $clog2(SLOT_WIDTH);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_WIDTH - 1);
    // Unused when WARMUP_FRAMES is 0 because WARMUP is then never entered.
    localparam logic [15:0]   WARM_LAST = (WARMUP_FRAMES == 0) ? 16'd0 : 16'(WARMUP_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WARMUP = 2'b01,
        ST_RUN    = 2'b10,
        ST_DRAIN  = 2'b11
    } state_t;

    state_t        state_reg, state_next;
    logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
    logic          ws_reg, ws_next;
    logic [15:0]   warm_cnt_reg, warm_cnt_next;
    logic          left_lat_reg, left_lat_next;
    logic          right_lat_reg, right_lat_next;
    logic          from_run_reg, from_run_next;
    logic [15:0]   frame_count_reg, frame_count_next;
    logic          capture_en_reg, capture_en_next;
    logic          frame_start_reg, frame_start_next;
    logic          running_reg, running_next;

    logic slot_last;
    logic frame_last;
    logic capture_active;

    assign slot_last  = (bit_cnt_reg == BIT_LAST);
    assign frame_last = slot_last && ws_reg;

    // State and datapath registers
    always_ff @(posedge i2s_bclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= '0;
            ws_reg          <= 1'b0;
            warm_cnt_reg    <= '0;
            left_lat_reg    <= 1'b0;
            right_lat_reg   <= 1'b0;
            from_run_reg    <= 1'b0;
            frame_count_reg <= '0;
            capture_en_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            running_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            ws_reg          <= ws_next;
            warm_cnt_reg    <= warm_cnt_next;
            left_lat_reg    <= left_lat_next;
            right_lat_reg   <= right_lat_next;
            from_run_reg    <= from_run_next;
            frame_count_reg <= frame_count_next;
            capture_en_reg  <= capture_en_next;
            frame_start_reg <= frame_start_next;
            running_reg     <= running_next;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        ws_next          = ws_reg;
        warm_cnt_next    = warm_cnt_reg;
        left_lat_next    = left_lat_reg;
        right_lat_next   = right_lat_reg;
        from_run_next    = from_run_reg;
        frame_count_next = frame_count_reg;

        if (state_reg == ST_IDLE) begin
            bit_cnt_next = '0;
            ws_next      = 1'b0;
            if (enable) begin
                left_lat_next  = left_en;
                right_lat_next = right_en;
                warm_cnt_next  = '0;
                from_run_next  = 1'b0;
                state_next     = (WARMUP_FRAMES == 0) ? ST_RUN : ST_WARMUP;
            end
        end else begin
            // The wrap at the frame boundary also lands on bit 0 / ws 0,
            // which is exactly the IDLE entry condition.
            if (slot_last) begin
                bit_cnt_next = '0;
                ws_next      = ~ws_reg;
            end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end

            case (state_reg)
                ST_WARMUP: begin
                    if (!enable) begin
                        from_run_next = 1'b0;
                        state_next    = frame_last ? ST_IDLE : ST_DRAIN;
                    end else if (frame_last) begin
                        left_lat_next  = left_en;
                        right_lat_next = right_en;
                        if (warm_cnt_reg == WARM_LAST) begin
                            warm_cnt_next = '0;
                            state_next    = ST_RUN;
                        end else begin
                            warm_cnt_next = warm_cnt_reg + 16'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (frame_last) begin
                        frame_count_next = frame_count_reg + 16'd1;
                    end
                    if (!enable) begin
                        from_run_next = 1'b1;
                        state_next    = frame_last ? ST_IDLE : ST_DRAIN;
                    end else if (frame_last) begin
                        left_lat_next  = left_en;
                        right_lat_next = right_en;
                    end
                end
                default: begin
                    // DRAIN: enable is ignored until IDLE is reached.
                    if (frame_last) begin
                        state_next = ST_IDLE;
                        if (from_run_reg) begin
                            frame_count_next = frame_count_reg + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Output logic: computed from next values so the registered outputs line
    // up with the registered ws and state with no skew.
    always_comb begin
        capture_active   = (state_next == ST_RUN) ||
                           ((state_next == ST_DRAIN) && from_run_next);
        capture_en_next  = capture_active && (ws_next ? right_lat_next : left_lat_next);
        frame_start_next = capture_active && (bit_cnt_next == '0) && !ws_next;
        running_next     = (state_next == ST_RUN);
    end

    assign i2s_ws      = ws_reg;
    assign capture_en  = capture_en_reg;
    assign frame_start = frame_start_reg;
    assign running     = running_reg;
    assign state       = state_reg;
    assign frame_count = frame_count_reg;

endmodule
